// File: rtl/op_sequencer.sv
// Start/request/acknowledge sequencer with ack timeout, bounded retries, abort and error hold.
// Optional status outputs are enabled by defining OPSEQ_STATUS_EN.
module op_sequencer #(
    parameter int unsigned TIMEOUT   = 8,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned ERR_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       abort,
    input  logic       ack,
    input  logic       fail,
    output logic       rdy,
    output logic       start,
    output logic       req,
    output logic       endd,
    output logic       er,
    output logic       stop,
    output logic       rt,
    output logic       interrupt,
    output logic [2:0] retry_cnt
`ifdef OPSEQ_STATUS_EN
    ,
    output logic       status_valid,
    output logic [1:0] status
`endif
);

    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);
    localparam logic [1:0] ERR_LAST  = 2'(ERR_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RETRY,
        S_DONE,
        S_ERR,
        S_STOP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       settle;
    logic [7:0] timer;
    logic [1:0] err_cnt;
    logic       attempt_failed;

    assign attempt_failed = (ack && fail) || (!ack && (timer == TMO_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!settle && go && !abort) state_nxt = S_START;
            S_START: state_nxt = abort ? S_STOP : S_WAIT;
            S_WAIT: begin
                if (abort)                state_nxt = S_STOP;
                else if (ack && !fail)    state_nxt = S_DONE;
                else if (attempt_failed)  state_nxt = (retry_cnt < RETRY_LIM) ? S_RETRY : S_ERR;
            end
            S_RETRY: state_nxt = abort ? S_STOP : S_START;
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   if (err_cnt == ERR_LAST) state_nxt = S_IDLE;
            S_STOP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rdy       = (state == S_IDLE) && !settle;
        start     = (state == S_START);
        req       = (state == S_WAIT);
        endd      = (state == S_DONE);
        er        = (state == S_ERR);
        stop      = (state == S_STOP);
        rt        = (state == S_RETRY);
        interrupt = (state == S_DONE) || ((state == S_ERR) && (err_cnt == 2'd0));
    end

    // settle forces one non-ready IDLE cycle after every terminal state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle    <= 1'b1;
            timer     <= '0;
            retry_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if ((state_nxt == S_IDLE) &&
                ((state == S_DONE) || (state == S_ERR) || (state == S_STOP)))
                settle <= 1'b1;
            else if (state == S_IDLE)
                settle <= 1'b0;

            if (state == S_START)     timer <= '0;
            else if (state == S_WAIT) timer <= timer + 8'd1;

            if ((state == S_IDLE) && (state_nxt == S_START))
                retry_cnt <= '0;
            else if ((state == S_RETRY) && (retry_cnt != 3'd7))
                retry_cnt <= retry_cnt + 3'd1;

            if (state == S_ERR) err_cnt <= err_cnt + 2'd1;
            else                err_cnt <= '0;
        end
    end

`ifdef OPSEQ_STATUS_EN
    assign status_valid = (state == S_DONE) || (state == S_STOP) ||
                          ((state == S_ERR) && (err_cnt == 2'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status <= '0;
        end else if (state_nxt != state) begin
            case (state_nxt)
                S_DONE:  status <= 2'b00;
                S_ERR:   status <= 2'b01;
                S_STOP:  status <= 2'b10;
                default: status <= status;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: directed test-plan transactions plus randomized ones,
// checked cycle by cycle against a transaction-level expectation built in the bench.
module tb_op_sequencer;

    localparam int unsigned TIMEOUT   = 8;
    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned ERR_HOLD  = 2;

    localparam logic [7:0] E_RDY   = 8'h80;
    localparam logic [7:0] E_START = 8'h40;
    localparam logic [7:0] E_REQ   = 8'h20;
    localparam logic [7:0] E_END   = 8'h10;
    localparam logic [7:0] E_ER    = 8'h08;
    localparam logic [7:0] E_STOP  = 8'h04;
    localparam logic [7:0] E_RT    = 8'h02;
    localparam logic [7:0] E_INT   = 8'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go = 1'b0, abort = 1'b0, ack = 1'b0, fail = 1'b0;
    logic       rdy, start, req, endd, er, stop, rt, interrupt;
    logic [2:0] retry_cnt;
`ifdef OPSEQ_STATUS_EN
    logic       status_valid;
    logic [1:0] status;
`endif

    int         n_checks = 0;
    int         n_err    = 0;
    logic [2:0] rc_m     = 3'd0;
    logic [1:0] st_m     = 2'b00;

    op_sequencer #(
        .TIMEOUT  (TIMEOUT),
        .MAX_RETRY(MAX_RETRY),
        .ERR_HOLD (ERR_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .abort    (abort),
        .ack      (ack),
        .fail     (fail),
        .rdy      (rdy),
        .start    (start),
        .req      (req),
        .endd     (endd),
        .er       (er),
        .stop     (stop),
        .rt       (rt),
        .interrupt(interrupt),
        .retry_cnt(retry_cnt)
`ifdef OPSEQ_STATUS_EN
        ,
        .status_valid(status_valid),
        .status      (status)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs just after the edge, check Moore outputs mid-cycle.
    task automatic cyc(input logic r, input logic g, input logic a, input logic k, input logic f,
                       input logic [7:0] ev, input logic sv, input logic [1:0] code,
                       input string tag);
        logic [7:0] obs;
        rst = r; go = g; abort = a; ack = k; fail = f;
        if (!r) begin
            rc_m = 3'd0;
            st_m = 2'b00;
        end
        if (sv) st_m = code;
        #3;
        obs = {rdy, start, req, endd, er, stop, rt, interrupt};
        n_checks++;
        assert (obs === ev) else begin
            n_err++;
            $error("FAIL %s: outputs=%b expected=%b", tag, obs, ev);
        end
        n_checks++;
        assert (retry_cnt === rc_m) else begin
            n_err++;
            $error("FAIL %s_retry_cnt: got=%0d expected=%0d", tag, retry_cnt, rc_m);
        end
`ifdef OPSEQ_STATUS_EN
        n_checks++;
        assert ({status_valid, status} === {sv, st_m}) else begin
            n_err++;
            $error("FAIL %s_status: got=%b/%b expected=%b/%b", tag, status_valid, status, sv, st_m);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic settle_cyc();
        cyc(1, rb(), rb(), rb(), rb(), 8'h00, 1'b0, 2'b00, "settle");
    endtask

    task automatic stop_cyc();
        cyc(1, rb(), rb(), rb(), rb(), E_STOP, 1'b1, 2'b10, "stop");
        settle_cyc();
    endtask

    // plan 0 random; 1 ack ok on 3rd WAIT cycle; 2 never ack; 3 fail then ok; 4 abort on 3rd WAIT cycle
    task automatic run_txn(input int plan);
        int  outcome, d, n;
        logic ab, g, lst;
        if (plan == 0) begin
            repeat ($urandom_range(0, 2)) begin
                g = rb();
                cyc(1, g, g ? 1'b1 : rb(), rb(), rb(), E_RDY, 1'b0, 2'b00, "idle");
            end
        end
        cyc(1, 1, 0, rb(), rb(), E_RDY, 1'b0, 2'b00, "accept");
        rc_m = 3'd0;
        for (int attempt = 0; attempt < 16; attempt++) begin
            ab = (plan == 0) && ($urandom_range(0, 15) == 0);
            cyc(1, rb(), ab, rb(), rb(), E_START, 1'b0, 2'b00, "start");
            if (ab) begin
                stop_cyc();
                return;
            end
            case (plan)
                1: begin outcome = 0; d = 2; end
                2: begin outcome = 2; d = 0; end
                3: begin outcome = (attempt == 0) ? 1 : 0; d = (attempt == 0) ? 1 : 3; end
                4: begin outcome = 3; d = 2; end
                default: begin
                    n = $urandom_range(0, 9);
                    outcome = (n == 0) ? 3 : (n < 4) ? 2 : (n < 7) ? 1 : 0;
                    d = $urandom_range(0, TIMEOUT - 1);
                end
            endcase
            n = (outcome == 2) ? TIMEOUT : d + 1;
            for (int w = 0; w < n; w++) begin
                lst = (w == n - 1);
                cyc(1, rb(),
                    lst && (outcome == 3),
                    lst && (outcome <= 1) ? 1'b1 : (lst && outcome == 3) ? rb() : 1'b0,
                    (lst && outcome == 0) ? 1'b0 : (lst && outcome == 1) ? 1'b1 : rb(),
                    E_REQ, 1'b0, 2'b00, "wait");
            end
            if (outcome == 3) begin
                stop_cyc();
                return;
            end
            if (outcome == 0) begin
                cyc(1, rb(), rb(), rb(), rb(), E_END | E_INT, 1'b1, 2'b00, "done");
                settle_cyc();
                return;
            end
            if (int'(rc_m) < MAX_RETRY) begin
                ab = (plan == 0) && ($urandom_range(0, 15) == 0);
                cyc(1, rb(), ab, rb(), rb(), E_RT, 1'b0, 2'b00, "retry");
                rc_m = rc_m + 3'd1;
                if (ab) begin
                    stop_cyc();
                    return;
                end
            end else begin
                for (int e = 0; e < ERR_HOLD; e++)
                    cyc(1, rb(), rb(), rb(), rb(), (e == 0) ? (E_ER | E_INT) : E_ER,
                        e == 0, 2'b01, "err");
                settle_cyc();
                return;
            end
        end
    endtask

    task automatic reset_in_wait();
        cyc(1, 1, 0, 0, 0, E_RDY, 1'b0, 2'b00, "accept_r");
        rc_m = 3'd0;
        cyc(1, 0, 0, 0, 0, E_START, 1'b0, 2'b00, "start_r");
        cyc(1, 0, 0, 0, 0, E_REQ, 1'b0, 2'b00, "wait_r");
        cyc(1, 0, 0, 0, 0, E_REQ, 1'b0, 2'b00, "wait_r");
        cyc(0, rb(), rb(), rb(), rb(), 8'h00, 1'b0, 2'b00, "rst_mid_wait");
        cyc(0, rb(), rb(), rb(), rb(), 8'h00, 1'b0, 2'b00, "rst_held");
        cyc(1, rb(), rb(), rb(), rb(), 8'h00, 1'b0, 2'b00, "rst_release");
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0, 8'h00, 1'b0, 2'b00, "reset");
        cyc(0, 1, 0, 1, 0, 8'h00, 1'b0, 2'b00, "reset");
        cyc(1, 0, 0, 0, 0, 8'h00, 1'b0, 2'b00, "reset_release");
        cyc(1, 0, 0, 0, 0, E_RDY, 1'b0, 2'b00, "rdy_after_reset");

        run_txn(1);
        cyc(1, 1, 1, 0, 0, E_RDY, 1'b0, 2'b00, "go_with_abort");
        cyc(1, 1, 1, 1, 1, E_RDY, 1'b0, 2'b00, "go_with_abort");
        run_txn(2);
        run_txn(3);
        run_txn(4);
        reset_in_wait();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) reset_in_wait();
            else                           run_txn(0);
        end
        cyc(1, 0, 0, 0, 0, E_RDY, 1'b0, 2'b00, "final_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
